// File: rtl/mem_copy_dma.sv
// mem_copy_dma
// Word-by-word memory-to-memory copy engine. Each word costs three cycles on
// the shared memory port: read address, read data capture, write.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  copy request (honoured only when idle)
//   src_addr, dst_addr     first source / destination word address
//   len                    number of words to copy (0 allowed)
//   abort                  cancel an active copy
//   mem_cmd                00 NONE, 01 MREAD, 10 MWRITE
//   mem_addr, write_data   memory address and write data
//   read_data              read return, valid the cycle after MREAD appears
//   busy                   high whenever not idle
//   done                   one-cycle completion pulse
//   remaining              words not yet written
module mem_copy_dma #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic          abort,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] remaining
);

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_MREAD  = 2'b01;
    localparam logic [1:0] CMD_MWRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [DW-1:0] buf_q, buf_d;

    // Next-state and datapath updates. Abort wins over every other transition
    // in the active states and leaves pointers and the word count untouched.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    state_d = (len != '0) ? RD_ADDR : DONE;
                end
            end
            RD_ADDR: begin
                state_d = abort ? IDLE : RD_DATA;
            end
            RD_DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    buf_d   = read_data;
                    state_d = WR;
                end
            end
            WR: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    src_d   = src_q + AW'(1);
                    dst_d   = dst_q + AW'(1);
                    rem_d   = rem_q - AW'(1);
                    state_d = (rem_q == AW'(1)) ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
        end
    end

    // Moore output decode from registered state and registered datapath only.
    always_comb begin
        mem_cmd    = CMD_NONE;
        mem_addr   = '0;
        write_data = '0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        remaining  = rem_q;
        case (state_q)
            RD_ADDR, RD_DATA: begin
                mem_cmd  = CMD_MREAD;
                mem_addr = src_q;
            end
            WR: begin
                mem_cmd    = CMD_MWRITE;
                mem_addr   = dst_q;
                write_data = buf_q;
            end
            default: begin
                mem_cmd = CMD_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: a behavioural memory answers the
// DUT's commands, expected memory transactions are queued when each copy is
// launched and compared as the DUT presents them.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [8:0]  len;
    logic        abort;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        busy;
    logic        done;
    logic [8:0]  remaining;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;

    logic [15:0] mem     [0:511];
    logic [15:0] ref_mem [0:511];
    logic        tb_we = 1'b0;
    logic [8:0]  tb_waddr = '0;
    logic [15:0] tb_wdata = '0;

    mem_copy_dma #(.AW(9), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after MREAD is seen.
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        if (mem_cmd == 2'b01) read_data <= mem[mem_addr];
        if (mem_cmd == 2'b10) mem[mem_addr] <= write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every memory command the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_cmd != 2'b00) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_cmd", {30'd0, mem_cmd}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("cmd", {30'd0, mem_cmd}, {30'd0, mon_e.cmd});
                check_eq("addr", {23'd0, mem_addr}, {23'd0, mon_e.addr});
                if (mon_e.cmd == 2'b10)
                    check_eq("wdata", {16'd0, write_data}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic tb_write(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_read(input logic [8:0] s);
        exp_q.push_back('{cmd: 2'b01, addr: s, data: 16'h0});
        exp_q.push_back('{cmd: 2'b01, addr: s, data: 16'h0});
    endtask

    task automatic push_word(input logic [8:0] s, input logic [8:0] d);
        push_read(s);
        exp_q.push_back('{cmd: 2'b10, addr: d, data: ref_mem[s]});
        ref_mem[d] = ref_mem[s];
    endtask

    // Launches one copy (start seen at edge 0) and observes cycles 1..window.
    task automatic run_copy(input string name, input logic [8:0] s, input logic [8:0] d,
                            input logic [8:0] l, input int abort_cyc, input int exp_rem_abort,
                            input int exp_done, input int exp_busy, input int hold_to);
        int done_cyc = 0;
        int done_cnt = 0;
        int busy_cnt = 0;
        int window;
        window = 3 * int'(l) + 4;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (c > hold_to) begin
                start = 1'b0;
            end else begin
                src_addr = s + 9'h100; dst_addr = d + 9'h100; len = 9'd7;
            end
            abort = (c == abort_cyc);
            if (c == 1) check_eq({name, "_rem_c1"}, {23'd0, remaining}, {23'd0, l});
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                check_eq({name, "_rem_done"}, {23'd0, remaining}, 32'd0);
            end
            if (abort_cyc != 0 && c == abort_cyc + 1) begin
                check_eq({name, "_idle_after_abort"}, {31'd0, busy}, 32'd0);
                check_eq({name, "_rem_abort"}, {23'd0, remaining}, exp_rem_abort);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check_eq({name, "_done_cycle"}, done_cyc, exp_done);
        check_eq({name, "_done_count"}, done_cnt, (exp_done != 0) ? 1 : 0);
        check_eq({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check_eq({name, "_txn_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        @(posedge clk);
        #1;
        check_eq("rst_cmd", {30'd0, mem_cmd}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_rem", {23'd0, remaining}, 32'd0);

        // Sources and cleared destinations.
        tb_write(9'h010, 16'h1111); tb_write(9'h011, 16'h2222); tb_write(9'h012, 16'h3333);
        for (int i = 0; i < 3; i++) tb_write(9'h020 + 9'(i), 16'h0000);
        for (int i = 0; i < 4; i++) tb_write(9'h030 + 9'(i), 16'hC000 + 16'(i));
        for (int i = 0; i < 4; i++) tb_write(9'h040 + 9'(i), 16'h0000);
        tb_write(9'h1FF, 16'hAAAA); tb_write(9'h000, 16'h5555);
        tb_write(9'h0F0, 16'h0000); tb_write(9'h0F1, 16'h0000);
        for (int i = 0; i < 3; i++) tb_write(9'h080 + 9'(i), 16'hA001 + 16'(i));
        for (int i = 0; i < 3; i++) tb_write(9'h090 + 9'(i), 16'h0000);
        tb_write(9'h190, 16'h0000);
        tb_write(9'h050, 16'hBEEF); tb_write(9'h051, 16'hCAFE);
        tb_write(9'h060, 16'h0000); tb_write(9'h061, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic three-word copy.
        for (int i = 0; i < 3; i++) push_word(9'h010 + 9'(i), 9'h020 + 9'(i));
        run_copy("basic", 9'h010, 9'h020, 9'd3, 0, 0, 10, 10, 0);
        check_eq("basic_ram20", {16'd0, mem[9'h020]}, 32'h1111);
        check_eq("basic_ram21", {16'd0, mem[9'h021]}, 32'h2222);
        check_eq("basic_ram22", {16'd0, mem[9'h022]}, 32'h3333);

        // Zero-length copy: done in cycle 1, no memory traffic.
        run_copy("len0", 9'h010, 9'h020, 9'd0, 0, 0, 1, 1, 0);

        // Address wrap from the top of the space.
        push_word(9'h1FF, 9'h0F0);
        push_word(9'h000, 9'h0F1);
        run_copy("wrap", 9'h1FF, 9'h0F0, 9'd2, 0, 0, 7, 7, 0);
        check_eq("wrap_ramF0", {16'd0, mem[9'h0F0]}, 32'hAAAA);
        check_eq("wrap_ramF1", {16'd0, mem[9'h0F1]}, 32'h5555);

        // start held with other addresses while busy must not disturb the copy.
        for (int i = 0; i < 3; i++) push_word(9'h080 + 9'(i), 9'h090 + 9'(i));
        run_copy("busy_start", 9'h080, 9'h090, 9'd3, 0, 0, 10, 10, 5);
        check_eq("busy_start_ram92", {16'd0, mem[9'h092]}, 32'hA003);
        check_eq("busy_start_ram190", {16'd0, mem[9'h190]}, 32'h0000);

        // Abort during RD_DATA of the second word.
        push_word(9'h030, 9'h040);
        push_read(9'h031);
        run_copy("abort", 9'h030, 9'h040, 9'd4, 5, 3, 0, 5, 0);
        check_eq("abort_ram40", {16'd0, mem[9'h040]}, 32'hC000);
        check_eq("abort_ram41", {16'd0, mem[9'h041]}, 32'h0000);

        // Asynchronous reset in the middle of a WR cycle.
        push_read(9'h050);
        @(negedge clk);
        src_addr = 9'h050; dst_addr = 9'h060; len = 9'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_cmd", {30'd0, mem_cmd}, 32'd0);
        check_eq("mrst_addr", {23'd0, mem_addr}, 32'd0);
        check_eq("mrst_wdata", {16'd0, write_data}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_done", {31'd0, done}, 32'd0);
        check_eq("mrst_rem", {23'd0, remaining}, 32'd0);
        #1 rst_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check_eq("mrst_busy_after", busy_cnt, 0);
        check_eq("mrst_done_after", done_cnt, 0);
        check_eq("mrst_txn_left", exp_q.size(), 0);
        check_eq("mrst_ram60", {16'd0, mem[9'h060]}, 32'h0000);

        // First start after reset release is honoured.
        push_word(9'h050, 9'h060);
        push_word(9'h051, 9'h061);
        run_copy("post_rst", 9'h050, 9'h060, 9'd2, 0, 0, 7, 7, 0);
        check_eq("post_rst_ram61", {16'd0, mem[9'h061]}, 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
